uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared defaults, arbiter state encoding and a width helper for the UART
// transmit arbiter slice.
package uart_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 40000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   // Keeps index/counter vectors at least one bit wide for degenerate sizes.
   function automatic int safe_clog2(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: the first active request found after the
// previous owner (wrapping) wins, reported both one-hot and as an index.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = safe_clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   logic             found;
   logic [IDX_W-1:0] cand;
   int               sum;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      sum   = 0;
      // Offsets 1..NUM_REQ so the previous owner is considered last.
      for (int i = 1; i <= NUM_REQ; i++) begin
         sum  = int'(last) + i;
         cand = IDX_W'(sum % NUM_REQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters: round-robin grant, one
// start pulse per frame, then ack on tx_done or abandon after a WAIT timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
   input  logic                          i_tx_done,
   output logic                          o_tx_start,
   output logic [DATA_WIDTH-1:0]         o_tx_byte,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic                          o_timeout,
   output logic                          o_busy
);

   localparam int               IDX_W      = safe_clog2(NUM_REQ);
   localparam int               CNT_W      = safe_clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

   arb_state_e            state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [DATA_WIDTH-1:0] byte_q, byte_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  timeout_q, timeout_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IDX_W-1:0]      pick_idx;
   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign req_bytes[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req  (i_req),
      .last (last_q),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      last_d    = last_q;
      byte_d    = byte_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (|i_req) begin
               grant_d = pick_gnt;
               owner_d = pick_idx;
               byte_d  = req_bytes[pick_idx];
               state_d = START;
            end
         end
         START: begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = WAIT;
         end
         WAIT: begin
            // Done is checked first so a same-cycle completion is never a timeout.
            if (i_tx_done) begin
               timeout_d = 1'b0;
               state_d   = RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            last_d  = owner_q;
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         last_q    <= LAST_RESET;
         byte_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         byte_q    <= byte_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_tx_start = (state_q == START);
   assign o_tx_byte  = byte_q;
   assign o_grant    = grant_q;
   assign o_ack      = (state_q == RELEASE) ? grant_q : '0;
   assign o_timeout  = (state_q == RELEASE) && timeout_q;
   assign o_busy     = (state_q != IDLE);

endmodule
